// File: rtl/tr_switch_pkg.sv
// Shared types and helpers for the T/R switch sequencer: FSM state encoding
// and a bounded one-hot channel decoder.
package tr_switch_pkg;

  localparam int unsigned MAX_CH = 32;

  typedef enum logic [2:0] {
    S_OFF,
    S_RX,
    S_GUARD_RT,
    S_TX_ARM,
    S_TX,
    S_PA_OFF,
    S_GUARD_TR
  } state_t;

  // Out-of-range indices decode to all-zero so a bad channel never closes a switch.
  function automatic logic [MAX_CH-1:0] ch_onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_CH-1:0] oh;
    oh = '0;
    if ((idx < n) && (idx < MAX_CH)) oh[idx[4:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tr_dwell_timer.sv
// Loadable down-counter that holds at zero; used for dwell timing and the
// optional TX watchdog.
module tr_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)                r_count <= '0;
    else if (i_load)        r_count <= i_load_val;
    else if (r_count != '0) r_count <= r_count - W'(1);
  end

  assign o_value = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/tr_switch_sequencer.sv
// Break-before-make T/R switch sequencer for NUM_CH antennas with guard and
// settle dwells. Optional TX watchdog enabled by defining TR_WATCHDOG_EN.
module tr_switch_sequencer
  import tr_switch_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int GUARD_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_TX_CYCLES = 1024,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_req,
  input  logic [CH_W-1:0]   tx_ch,
  input  logic [CH_W-1:0]   rx_ch,
  output logic              tx_ready,
  output logic [NUM_CH-1:0] rx_en,
  output logic [NUM_CH-1:0] tx_en,
  output logic              lna_en,
  output logic              pa_en,
  output logic              ch_err,
  output logic              tx_timeout
);

  localparam int GS_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int DW_MAX = (GS_MAX > MAX_TX_CYCLES) ? GS_MAX : MAX_TX_CYCLES;
  localparam int CNT_W  = $clog2(DW_MAX + 1);

  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_tx_ch_q, r_rx_ch_q, w_tx_ch_nxt, w_rx_ch_nxt;
  logic              r_boot, r_err_lock;
  logic              w_tx_err, w_rx_err, w_wd_block;
  logic              w_tx_ch_ok, w_rx_ch_ok;
  logic              w_dwell_load, w_dwell_zero;
  logic [CNT_W-1:0]  w_dwell_val, w_dwell_value;
  logic [NUM_CH-1:0] r_rx_en, r_tx_en;
  logic              r_lna_en, r_pa_en, r_tx_ready, r_ch_err;

  assign w_tx_ch_ok = (32'(tx_ch) < 32'(NUM_CH));
  assign w_rx_ch_ok = (32'(rx_ch) < 32'(NUM_CH));

`ifdef TR_WATCHDOG_EN
  logic             r_wd_block, r_tx_timeout, w_timeout, w_wd_zero;
  logic [CNT_W-1:0] w_wd_value;

  tr_dwell_timer #(.W(CNT_W)) u_wd_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     ((w_state_nxt == S_TX) && (r_state != S_TX)),
    .i_load_val (CNT_W'(MAX_TX_CYCLES - 1)),
    .o_value    (w_wd_value),
    .o_zero     (w_wd_zero)
  );

  // After a watchdog trip, TX stays locked out until tx_req is seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_block   <= 1'b0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_tx_timeout <= w_timeout;
      if (w_timeout)   r_wd_block <= 1'b1;
      else if (!tx_req) r_wd_block <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (w_wd_zero == (w_wd_value == '0));
  end

  assign w_wd_block = r_wd_block;
  assign tx_timeout = r_tx_timeout;
`else
  assign w_wd_block = 1'b0;
  assign tx_timeout = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_ch_nxt = r_tx_ch_q;
    w_rx_ch_nxt = r_rx_ch_q;
    w_tx_err    = 1'b0;
    w_rx_err    = 1'b0;
`ifdef TR_WATCHDOG_EN
    w_timeout   = 1'b0;
`endif
    unique case (r_state)
      S_OFF:      if (!r_boot && w_dwell_zero) w_state_nxt = S_RX;
      S_RX: begin
        if (tx_req && !w_wd_block) begin
          if (w_tx_ch_ok) begin
            w_tx_ch_nxt = tx_ch;
            w_state_nxt = S_GUARD_RT;
          end else if (!r_err_lock) begin
            w_tx_err = 1'b1;
          end
        end
      end
      S_GUARD_RT: begin
        if (!tx_req)           w_state_nxt = S_GUARD_TR;
        else if (w_dwell_zero) w_state_nxt = S_TX_ARM;
      end
      S_TX_ARM: begin
        if (!tx_req)           w_state_nxt = S_GUARD_TR;
        else if (w_dwell_zero) w_state_nxt = S_TX;
      end
      S_TX: begin
        if (!tx_req) w_state_nxt = S_PA_OFF;
`ifdef TR_WATCHDOG_EN
        else if (w_wd_zero) begin
          w_state_nxt = S_PA_OFF;
          w_timeout   = 1'b1;
        end
`endif
      end
      S_PA_OFF:   if (w_dwell_zero) w_state_nxt = S_GUARD_TR;
      S_GUARD_TR: if (w_dwell_zero) w_state_nxt = S_RX;
      default:    w_state_nxt = S_OFF;
    endcase

    // RX channel is captured once per RX entry; a bad index falls back to 0.
    if ((w_state_nxt == S_RX) && (r_state != S_RX)) begin
      w_rx_ch_nxt = w_rx_ch_ok ? rx_ch : '0;
      w_rx_err    = !w_rx_ch_ok;
    end
  end

  always_comb begin
    unique case (w_state_nxt)
      S_OFF, S_GUARD_RT, S_GUARD_TR: w_dwell_val = GUARD_LOAD;
      S_TX_ARM, S_PA_OFF:            w_dwell_val = SETTLE_LOAD;
      default:                       w_dwell_val = '0;
    endcase
  end

  // The first cycle out of reset counts as entry into S_OFF.
  assign w_dwell_load = r_boot || (w_state_nxt != r_state);

  tr_dwell_timer #(.W(CNT_W)) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dwell_load),
    .i_load_val (w_dwell_val),
    .o_value    (w_dwell_value),
    .o_zero     (w_dwell_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) assert (w_dwell_zero == (w_dwell_value == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_tx_ch_q  <= '0;
      r_rx_ch_q  <= '0;
      r_boot     <= 1'b1;
      r_err_lock <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_ch_q  <= w_tx_ch_nxt;
      r_rx_ch_q  <= w_rx_ch_nxt;
      r_boot     <= 1'b0;
      r_err_lock <= tx_req && (r_err_lock || w_tx_err);
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_en    <= '0;
      r_tx_en    <= '0;
      r_lna_en   <= 1'b0;
      r_pa_en    <= 1'b0;
      r_tx_ready <= 1'b0;
      r_ch_err   <= 1'b0;
    end else begin
      r_rx_en    <= (w_state_nxt == S_RX) ?
                    NUM_CH'(ch_onehot(32'(w_rx_ch_nxt), 32'(NUM_CH))) : '0;
      r_tx_en    <= (w_state_nxt inside {S_TX_ARM, S_TX, S_PA_OFF}) ?
                    NUM_CH'(ch_onehot(32'(w_tx_ch_nxt), 32'(NUM_CH))) : '0;
      r_lna_en   <= (w_state_nxt == S_RX);
      r_pa_en    <= (w_state_nxt == S_TX);
      r_tx_ready <= (w_state_nxt == S_TX);
      r_ch_err   <= w_tx_err || w_rx_err;
    end
  end

  assign rx_en    = r_rx_en;
  assign tx_en    = r_tx_en;
  assign lna_en   = r_lna_en;
  assign pa_en    = r_pa_en;
  assign tx_ready = r_tx_ready;
  assign ch_err   = r_ch_err;

endmodule
